imm_encoder: RTL and testbench

Pipelined immediate encoder: accepts a 32-bit template instruction, an immediate type and a 32-bit immediate value, and produces the instruction word with the immediate scattered into the format-specific bit fields. It is the inverse of the decode-side immediate extension and sits in the trap/interrupt front end, where hardware-generated JAL/branch/store instructions are built before injection into the fetch stream. It also serves as a round-trip checker in verification. Flow is valid/ready on both sides, with a two-stage pipeline and a saturating error counter.

---
 rtl/imm_encoder_pkg.sv | 34 +++
 rtl/imm_encoder_packer.sv | 57 +++++
 rtl/imm_encoder.sv | 102 ++++++++++
 tb/tb_imm_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg
//   Shared definitions for the immediate encoder: immediate-type codes,
//   error codes, counter limit and a sign-field helper.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_U  = 3'd0,
        IMM_J  = 3'd1,
        IMM_I  = 3'd2,
        IMM_B  = 3'd3,
        IMM_S  = 3'd4,
        IMM_NO = 3'd5
    } imm_type_e;

    typedef enum logic [1:0] {
        IMM_ERR_NONE  = 2'd0,
        IMM_ERR_RANGE = 2'd1,
        IMM_ERR_ALIGN = 2'd2
    } imm_err_e;

    localparam logic [15:0] ERR_CNT_MAX = '1;

    // True when imm[31:lsb] are all copies of the sign bit, i.e. the value
    // is representable as a signed field whose top bit sits at lsb.
    function automatic logic upper_uniform(input logic [31:0] imm, input int unsigned lsb);
        logic ok;
        ok = 1'b1;
        for (int unsigned b = lsb; b < 32; b++) begin
            if (imm[b] != imm[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_encoder_packer.sv
// immFieldPacker
//   Combinational scatter of a 32-bit immediate into the format-specific
//   instruction fields, plus alignment/range classification.
//   Ports:
//     template  in  32  instruction template, non-immediate bits kept
//     imm_type  in   3  immediate format code (imm_type_e)
//     imm       in  32  signed immediate value
//     instr     out 32  template with immediate fields overwritten
//     err       out  2  imm_err_e; ALIGN takes priority over RANGE
module immFieldPacker
    import imm_encoder_pkg::*;
(
    input  logic [31:0] template,
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic [1:0]  err
);

    always_comb begin
        instr = template;
        err   = IMM_ERR_NONE;
        case (imm_type)
            IMM_U: begin
                instr[31:12] = imm[31:12];
                if (imm[11:0] != '0) err = IMM_ERR_ALIGN;
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                if (imm[0])                       err = IMM_ERR_ALIGN;
                else if (!upper_uniform(imm, 20)) err = IMM_ERR_RANGE;
            end
            IMM_I: begin
                instr[31:20] = imm[11:0];
                if (!upper_uniform(imm, 11)) err = IMM_ERR_RANGE;
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                if (!upper_uniform(imm, 11)) err = IMM_ERR_RANGE;
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                if (imm[0])                       err = IMM_ERR_ALIGN;
                else if (!upper_uniform(imm, 12)) err = IMM_ERR_RANGE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder
//   Two-stage valid/ready pipeline around immFieldPacker with a saturating
//   count of erroring results handed to the consumer.
//   Ports:
//     clk_i        in   1  clock, rising edge
//     rst_i        in   1  synchronous active-high reset
//     in_valid_i   in   1  request valid
//     in_ready_o   out  1  request can be accepted this cycle
//     template_i   in  32  instruction template
//     imm_type_i   in   3  immediate format code
//     imm_i        in  32  signed immediate
//     out_valid_o  out  1  result valid
//     out_ready_i  in   1  consumer accepts result
//     instr_o      out 32  encoded instruction
//     err_o        out  2  0 ok, 1 RANGE, 2 ALIGN
//     err_cnt_o    out 16  saturating count of consumed erroring results
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] template_i,
    input  logic [2:0]  imm_type_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [1:0]  err_o,
    output logic [15:0] err_cnt_o
);

    logic        s1_valid;
    logic [31:0] s1_template;
    logic [2:0]  s1_type;
    logic [31:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic [1:0]  s2_err;
    logic [15:0] err_cnt;

    logic        s1_load;
    logic        s2_load;
    logic [31:0] packed_instr;
    logic [1:0]  packed_err;

    // in_ready_o depends combinationally on out_ready_i so a full pipeline
    // can shift without a bubble.
    assign s2_load    = !s2_valid || out_ready_i;
    assign s1_load    = !s1_valid || s2_load;
    assign in_ready_o = s1_load;

    immFieldPacker u_packer (
        .template (s1_template),
        .imm_type (s1_type),
        .imm      (s1_imm),
        .instr    (packed_instr),
        .err      (packed_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_template <= '0;
            s1_type     <= '0;
            s1_imm      <= '0;
            s2_valid    <= 1'b0;
            s2_instr    <= '0;
            s2_err      <= '0;
            err_cnt     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    s1_template <= template_i;
                    s1_type     <= imm_type_i;
                    s1_imm      <= imm_i;
                end
            end
            // Data only moves with a valid entry so the output word stays
            // at the last result while the pipeline is empty.
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_instr <= packed_instr;
                    s2_err   <= packed_err;
                end
            end
            if (s2_valid && out_ready_i && (s2_err != IMM_ERR_NONE) && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign instr_o     = s2_instr;
    assign err_o       = s2_err;
    assign err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] template_v;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [1:0]  err;
    logic [15:0] err_cnt;

    imm_encoder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .template_i  (template_v),
        .imm_type_i  (imm_type),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .instr_o     (instr),
        .err_o       (err),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model_instr(input logic [31:0] t, input logic [2:0] ty,
                                                input logic [31:0] v);
        case (ty)
            3'd0: return {v[31:12], t[11:0]};
            3'd1: return {v[20], v[10:1], v[11], v[19:12], t[11:0]};
            3'd2: return {v[11:0], t[19:0]};
            3'd4: return {v[11:5], t[24:12], v[4:0], t[6:0]};
            3'd3: return {v[12], v[10:5], t[24:12], v[4:1], v[11], t[6:0]};
            default: return t;
        endcase
    endfunction

    function automatic logic [1:0] model_err(input logic [2:0] ty, input logic [31:0] v);
        int s;
        s = int'(signed'(v));
        case (ty)
            3'd0: return (v % 32'd4096 != 0) ? 2'd2 : 2'd0;
            3'd2, 3'd4: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
            3'd3: begin
                if (v % 32'd2 != 0) return 2'd2;
                return (s < -4096 || s > 4094) ? 2'd1 : 2'd0;
            end
            3'd1: begin
                if (v % 32'd2 != 0) return 2'd2;
                return (s < -1048576 || s > 1048574) ? 2'd1 : 2'd0;
            end
            default: return 2'd0;
        endcase
    endfunction

    // Decode-side immediate extension, used to round-trip legal encodings.
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] ty);
        case (ty)
            3'd0: return {i[31:12], 12'b0};
            3'd1: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd2: return {{20{i[31]}}, i[31:20]};
            3'd4: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return i;
        endcase
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  err;
        logic [2:0]  ty;
        logic [31:0] imm;
    } exp_t;

    exp_t        expq[$];
    int          inflight = 0;
    logic [15:0] model_cnt = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [1:0]  prev_err = '0;
    logic        rand_ready_en = 1'b0;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expq.delete();
            inflight   = 0;
            model_cnt  = '0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(inflight < 2 || out_ready));
            check("err_cnt", 32'(err_cnt), 32'(model_cnt));
            if (prev_stall) begin
                check("stall_instr", instr, prev_instr);
                check("stall_err", 32'(err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("instr", instr, e.instr);
                    check("err", 32'(err), 32'(e.err));
                    if (e.err == 2'd0 && e.ty <= 3'd4)
                        check("roundtrip", extend(instr, e.ty), e.imm);
                    if (e.err != 2'd0 && model_cnt != 16'hFFFF)
                        model_cnt = model_cnt + 16'd1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = instr;
            prev_err   = err;
            inflight   = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            if (in_valid && in_ready) begin
                e.instr = model_instr(template_v, imm_type, imm);
                e.err   = model_err(imm_type, imm);
                e.ty    = imm_type;
                e.imm   = imm;
                expq.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] t, input logic [2:0] ty, input logic [31:0] v);
        logic got;
        got        = 1'b0;
        template_v = t;
        imm_type   = ty;
        imm        = v;
        in_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        in_valid = 1'b0;
        check("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (expq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm(input logic [2:0] ty);
        int unsigned c;
        logic [31:0] r;
        c = $urandom_range(0, 9);
        r = $urandom();
        if (c < 2) return r;
        case (ty)
            3'd0: return (c == 2) ? (r | 32'd1) : {r[31:12], 12'b0};
            3'd2, 3'd4: begin
                if (c == 3) return 32'hFFFF_F800;
                if (c == 4) return 32'd2047;
                if (c == 5) return 32'd2048;
                return 32'(int'($urandom_range(0, 4095)) - 2048);
            end
            3'd3: begin
                if (c == 3) return 32'hFFFF_F000;
                if (c == 4) return 32'd4094;
                if (c == 5) return 32'd4096;
                return 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'd1;
            end
            3'd1: begin
                if (c == 3) return 32'hFFF0_0000;
                if (c == 4) return 32'd1048574;
                if (c == 5) return 32'd1048576;
                return 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'd1;
            end
            default: return r;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] m;
        logic [2:0]  ty;
        int unsigned k;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        template_v = '0;
        imm_type   = '0;
        imm        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Model pinned against hand-computed values.
        check("pin_i2048_err", 32'(model_err(IMM_I, 32'd2048)), 32'd1);
        m = model_instr(32'h0, IMM_I, 32'd2048);
        check("pin_i2048_fld", 32'(m[31:20]), 32'h800);
        check("pin_b3_err", 32'(model_err(IMM_B, 32'd3)), 32'd2);
        check("pin_u_err", 32'(model_err(IMM_U, 32'h0000_1001)), 32'd2);
        m = model_instr(32'h0, IMM_U, 32'h0000_1001);
        check("pin_u_fld", 32'(m[31:12]), 32'h00001);
        check("pin_jal", model_instr(32'h0000_006F, IMM_J, 32'h0000_0800), 32'h0010_006F);
        check("pin_b_ext", extend(32'h8000_0000, IMM_B), 32'hFFFF_F000);

        // JAL latency: accepted before edge E1, visible after E2.
        send(32'h0000_006F, IMM_J, 32'h0000_0800);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_instr", instr, 32'h0010_006F);

        // Error classes and extremes.
        send(32'h0000_0013, IMM_I, 32'd2048);
        send(32'h0000_0063, IMM_B, 32'd3);
        send(32'h0000_0037, IMM_U, 32'h0000_1001);
        send(32'h0000_0013, IMM_I, 32'hFFFF_F800);
        send(32'h0000_0013, IMM_I, 32'd2047);
        send(32'h0000_0063, IMM_B, 32'hFFFF_F000);
        send(32'h0000_0063, IMM_B, 32'd4094);
        send(32'h0000_006F, IMM_J, 32'hFFF0_0000);
        send(32'h0000_006F, IMM_J, 32'd1048574);
        drain();

        // Backpressure: two accepted, third held off.
        out_ready = 1'b0;
        send(32'h1111_1023, IMM_S, 32'd100);
        send(32'h2222_2013, IMM_I, 32'hFFFF_FFF0);
        template_v = 32'h3333_3063;
        imm_type   = IMM_B;
        imm        = 32'd64;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random consumer backpressure.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 4)      ty = 3'(k);
            else if (k == 5) ty = IMM_NO;
            else if (k == 6) ty = 3'($urandom_range(6, 7));
            else             ty = 3'($urandom_range(0, 4));
            send($urandom(), ty, rand_imm(ty));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset with two entries queued.
        out_ready = 1'b0;
        send(32'h0000_0013, IMM_I, 32'd5000);
        send(32'h0000_0013, IMM_I, 32'd6000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_output", 32'(out_valid), 32'd0);

        // Counter saturation: 65535 erroring results, then two more.
        for (int n = 0; n < 65537; n++) send(32'h0000_0013, IMM_I, 32'd2048);
        send(32'h1234_5678, IMM_NO, $urandom());
        drain();
        check("cnt_saturated", 32'(err_cnt), 32'h0000_FFFF);
        check("no_type_instr", instr, 32'h1234_5678);
        check("no_type_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
